// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder, {c,s} = a + b + cin.
//   WIDTH=1 gives the classic 1-bit full adder (s = a^b^cin, c = majority).
//   The cells are chained combinationally, and one register stage follows
//   the chain. This gives a latency of one clock and one operation per cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      async active-low reset; clears s, c, out_valid at once
//   in_valid   qualifies a, b, cin for this cycle
//   a, b       unsigned operands [WIDTH-1:0]
//   cin        carry into bit 0
//   s          registered sum [WIDTH-1:0]
//   c          registered carry-out of the MSB
//   out_valid  s/c were loaded at the last edge

// One bit cell of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic k_in,
  output logic sum,
  output logic k_out
);
  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ k_in;
  assign k_out = (a & b) | (k_in & p);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             out_valid
);
  // k[i] is the carry into cell i. k[WIDTH] is the carry-out of the MSB.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] sum;

  assign k[0] = cin;

  fa_cell u_cell [WIDTH-1:0] (
    .a    (a),
    .b    (b),
    .k_in (k[WIDTH-1:0]),
    .sum  (sum),
    .k_out(k[WIDTH:1])
  );

  // The result registers load only when in_valid is high. This prevents
  // X/Z on idle operands from reaching s or c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      c <= 1'b0;
    end else if (in_valid) begin
      s <= sum;
      c <= k[WIDTH];
    end
  end

  // out_valid follows in_valid with a one-cycle delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= in_valid;
  end
endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;
  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid1, a1, b1, cin1, s1, c1, ov1;
  logic       in_valid8, cin8, c8, ov8;
  logic [7:0] a8, b8, s8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
    .a(a1), .b(b1), .cin(cin1), .s(s1), .c(c1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
    .a(a8), .b(b8), .cin(cin8), .s(s8), .c(c8), .out_valid(ov8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge. Sampling happens 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum, WIDTH+1 bits wide.
  function automatic logic [1:0] ref1(input logic x, input logic y, input logic z);
    return 2'(int'(x) + int'(y) + int'(z));
  endfunction

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic z);
    return 9'(int'(x) + int'(y) + int'(z));
  endfunction

  initial begin
    logic [2:0] v;
    logic [8:0] e8;

    rst_n = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    in_valid8 = 1'b0; a8 = '0;   b8 = '0;   cin8 = 1'b0;

    // T1: reset dominates even with valid, toggling inputs.
    for (int i = 0; i < 3; i++) begin
      in_valid1 = 1'b1; a1 = ~a1; b1 = 1'b1; cin1 = 1'b1;
      in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'(i); cin8 = 1'b1;
      tick();
      chk("rst_s1",  {c1, s1}, 2'b00);
      chk("rst_ov1", ov1, 1'b0);
      chk("rst_s8",  {c8, s8}, 9'h000);
      chk("rst_ov8", ov8, 1'b0);
    end
    in_valid1 = 1'b0; in_valid8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // T2: exhaustive 1-bit truth table.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      in_valid1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      tick();
      chk("t2_cs", {c1, s1}, ref1(v[2], v[1], v[0]));
      chk("t2_ov", ov1, 1'b1);
    end

    // T3: hold while in_valid is low.
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    tick();
    chk("t3_load", {c1, s1}, 2'b10);
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
    tick();
    chk("t3_hold", {c1, s1}, 2'b10);
    chk("t3_ov",   ov1, 1'b0);
    tick();
    chk("t3_hold2", {c1, s1}, 2'b10);

    // T4: full carry propagation through the 8-bit chain.
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    tick();
    chk("t4_ripple", {c8, s8}, 9'h100);
    chk("t4_ov",     ov8, 1'b1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick();
    chk("t4_max", {c8, s8}, 9'h1FF);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    tick();
    chk("t4_min", {c8, s8}, 9'h000);

    // Unknown operands while idle must not disturb the held result.
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    tick();
    in_valid8 = 1'b0; a8 = 'x; b8 = 'x; cin8 = 1'bx;
    tick();
    chk("x_hold", {c8, s8}, 9'h100);
    chk("x_ov",   ov8, 1'b0);

    // Asynchronous reset between edges clears outputs immediately.
    in_valid8 = 1'b1; a8 = 8'h05; b8 = 8'h03; cin8 = 1'b0;
    tick();
    chk("async_pre", {c8, s8}, 9'h008);
    #3 rst_n = 1'b0;
    #1;
    chk("async_s8",  {c8, s8}, 9'h000);
    chk("async_ov8", ov8, 1'b0);
    in_valid8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // T5: back-to-back random vectors.
    for (int i = 0; i < 1000; i++) begin
      in_valid8 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      e8 = ref8(a8, b8, cin8);
      tick();
      chk("t5_cs", {c8, s8}, e8);
      chk("t5_ov", ov8, 1'b1);
    end
    in_valid8 = 1'b0;

    // T6: reset asserted before the pending 1+1+1 can be captured.
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_cs0", {c1, s1}, 2'b00);
    tick();
    chk("t6_cs1", {c1, s1}, 2'b00);
    chk("t6_ov",  ov1, 1'b0);
    in_valid1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid1 = 1'b1; a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
    tick();
    chk("t6_resume", {c1, s1}, 2'b01);
    chk("t6_res_ov", ov1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
